// File: rtl/decode.sv
// decode: instruction decode stage downstream of fetch.
// Classifies the older word of the 32-bit fetch window, registers the decoded
// fields and drives redirect controls back to fetch for flow-control words.
// Optional feature macro: DECODE_LONG_INSN_EN (enables the 32-bit format and SKIP).
module decode #(
  parameter int REDIRECT_HOLD = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fetchoutput,
  output logic        dec_valid,
  output logic [1:0]  dec_class,
  output logic [3:0]  dec_opcode,
  output logic [5:0]  dec_rd,
  output logic [5:0]  dec_ra,
  output logic [5:0]  dec_rb,
  output logic [9:0]  dec_imm,
  output logic        dec_long,
  output logic        dec_illegal,
  output logic [2:0]  pcjumpenable,
  output logic [8:0]  pcchange,
  output logic [5:0]  pclocation,
  output logic        flush
);

  localparam int CW = (REDIRECT_HOLD > 1) ? $clog2(REDIRECT_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(REDIRECT_HOLD - 1);

  typedef enum logic [1:0] {RUN, SKIP, REDIRECT, DRAIN} state_t;

  state_t        state;
  logic [CW-1:0] hold_cnt;

  logic [15:0] old_w;
  logic        is_bubble;
  logic        is_long;
  logic        is_flow;
  logic        is_illegal;
  logic [2:0]  jump_cmd;
  logic [8:0]  pc_chg;
  logic [5:0]  pc_loc;
  logic [5:0]  f_rd;
  logic [5:0]  f_ra;
  logic [5:0]  f_rb;
  logic [9:0]  f_imm;

  assign old_w = fetchoutput[31:16];

`ifndef DECODE_LONG_INSN_EN
  // Newer word only matters for the 32-bit format.
  logic unused_new;
  assign unused_new = ^fetchoutput[15:0];
`endif

  // Classify the older word and assemble its fields and redirect command.
  always_comb begin
    is_bubble  = (old_w == 16'h0000) || (old_w == 16'h0001);
    is_long    = 1'b0;
    is_flow    = 1'b0;
    is_illegal = 1'b0;
    jump_cmd   = 3'd0;
    pc_chg     = 9'd0;
    pc_loc     = 6'd0;
    f_rd       = {3'b000, old_w[8:6]};
    f_ra       = {3'b000, old_w[5:3]};
    f_rb       = {3'b000, old_w[2:0]};
    f_imm      = {4'b0000, old_w[5:0]};
    if (is_bubble) begin
      is_illegal = 1'b0;
    end else if (old_w[15]) begin
`ifdef DECODE_LONG_INSN_EN
      if (old_w[14:13] == 2'b11) begin
        is_illegal = 1'b1;
      end else begin
        is_long = 1'b1;
        f_rd    = {fetchoutput[8:6], old_w[8:6]};
        f_ra    = {fetchoutput[5:3], old_w[5:3]};
        f_rb    = {fetchoutput[2:0], old_w[2:0]};
        f_imm   = {fetchoutput[12:9], old_w[5:0]};
      end
`else
      is_illegal = 1'b1;
`endif
    end else if (old_w[14:13] == 2'b11) begin
      case (old_w[12:9])
        4'd0: begin is_flow = 1'b1; jump_cmd = 3'd1; pc_chg = old_w[8:0]; end
        4'd1: begin is_flow = 1'b1; jump_cmd = 3'd4; pc_chg = old_w[8:0]; end
        4'd2: begin is_flow = 1'b1; jump_cmd = 3'd2; pc_loc = old_w[5:0]; end
        4'd3: begin is_flow = 1'b1; jump_cmd = 3'd3; pc_loc = old_w[5:0]; end
        default: is_illegal = 1'b1;
      endcase
    end else begin
      is_flow = 1'b0;
    end
  end

  // Decode FSM: registers all outputs and sequences skip/redirect/drain.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= RUN;
      hold_cnt     <= '0;
      dec_valid    <= 1'b0;
      dec_class    <= 2'd0;
      dec_opcode   <= 4'd0;
      dec_rd       <= 6'd0;
      dec_ra       <= 6'd0;
      dec_rb       <= 6'd0;
      dec_imm      <= 10'd0;
      dec_long     <= 1'b0;
      dec_illegal  <= 1'b0;
      pcjumpenable <= 3'd0;
      pcchange     <= 9'd0;
      pclocation   <= 6'd0;
      flush        <= 1'b0;
    end else begin
      dec_valid   <= 1'b0;
      dec_long    <= 1'b0;
      dec_illegal <= 1'b0;
      flush       <= 1'b0;
      case (state)
        RUN: begin
          if (is_bubble) begin
            state <= RUN;
          end else if (is_illegal) begin
            dec_illegal <= 1'b1;
            state       <= RUN;
          end else begin
            dec_valid  <= 1'b1;
            dec_long   <= is_long;
            dec_class  <= old_w[14:13];
            dec_opcode <= old_w[12:9];
            dec_rd     <= f_rd;
            dec_ra     <= f_ra;
            dec_rb     <= f_rb;
            dec_imm    <= f_imm;
            if (is_long) begin
              state <= SKIP;
            end else if (is_flow) begin
              pcjumpenable <= jump_cmd;
              pcchange     <= pc_chg;
              pclocation   <= pc_loc;
              hold_cnt     <= HOLD_LOAD;
              state        <= REDIRECT;
            end else begin
              state <= RUN;
            end
          end
        end
        SKIP: state <= RUN;
        REDIRECT: begin
          if (hold_cnt == '0) begin
            pcjumpenable <= 3'd0;
            flush        <= 1'b1;
            state        <= DRAIN;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        DRAIN: state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: scoreboard of expected per-cycle outputs.
module tb_decode;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] fetchoutput;
  logic        dec_valid, dec_long, dec_illegal, flush;
  logic [1:0]  dec_class;
  logic [3:0]  dec_opcode;
  logic [5:0]  dec_rd, dec_ra, dec_rb, pclocation;
  logic [9:0]  dec_imm;
  logic [2:0]  pcjumpenable;
  logic [8:0]  pcchange;

  typedef struct packed {
    logic valid; logic lng; logic ill; logic [2:0] pje; logic fl;
  } ctrl_t;
  typedef struct packed {
    logic [1:0] cls; logic [3:0] op; logic [5:0] rd; logic [5:0] ra; logic [5:0] rb; logic [9:0] imm;
  } fld_t;
  typedef struct packed {
    ctrl_t c; logic chk_chg; logic [8:0] chg; logic chk_loc; logic [5:0] loc; logic chk_f; fld_t f;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;
  ctrl_t oc;
  fld_t  of;

  assign oc = {dec_valid, dec_long, dec_illegal, pcjumpenable, flush};
  assign of = {dec_class, dec_opcode, dec_rd, dec_ra, dec_rb, dec_imm};

  decode #(.REDIRECT_HOLD(2)) dut (
    .clock(clock), .reset(reset), .fetchoutput(fetchoutput),
    .dec_valid(dec_valid), .dec_class(dec_class), .dec_opcode(dec_opcode),
    .dec_rd(dec_rd), .dec_ra(dec_ra), .dec_rb(dec_rb), .dec_imm(dec_imm),
    .dec_long(dec_long), .dec_illegal(dec_illegal), .pcjumpenable(pcjumpenable),
    .pcchange(pcchange), .pclocation(pclocation), .flush(flush)
  );

  always #5 clock = ~clock;

  // Expected outputs of a RUN-state decode of window w.
  function automatic exp_t model_run(input logic [31:0] w);
    exp_t r;
    logic [15:0] o;
    logic [15:0] n;
    o = w[31:16];
    n = w[15:0];
    r = '0;
    if (o == 16'h0000 || o == 16'h0001) return r;
    if (o[15]) begin
`ifdef DECODE_LONG_INSN_EN
      if (o[14:13] == 2'b11) r.c.ill = 1'b1;
      else begin
        r.c.valid = 1'b1; r.c.lng = 1'b1; r.chk_f = 1'b1;
        r.f = {o[14:13], o[12:9], n[8:6], o[8:6], n[5:3], o[5:3], n[2:0], o[2:0], n[12:9], o[5:0]};
      end
`else
      r.c.ill = 1'b1;
`endif
      return r;
    end
    if (o[14:13] == 2'b11 && o[12:9] >= 4'd4) begin
      r.c.ill = 1'b1;
      return r;
    end
    r.c.valid = 1'b1; r.chk_f = 1'b1;
    r.f = {o[14:13], o[12:9], 3'b000, o[8:6], 3'b000, o[5:3], 3'b000, o[2:0], 4'b0000, o[5:0]};
    if (o[14:13] == 2'b11) begin
      case (o[12:9])
        4'd0: begin r.c.pje = 3'd1; r.chk_chg = 1'b1; r.chg = o[8:0]; end
        4'd1: begin r.c.pje = 3'd4; r.chk_chg = 1'b1; r.chg = o[8:0]; end
        4'd2: begin r.c.pje = 3'd2; r.chk_loc = 1'b1; r.loc = o[5:0]; end
        default: begin r.c.pje = 3'd3; r.chk_loc = 1'b1; r.loc = o[5:0]; end
      endcase
    end
    return r;
  endfunction

  function automatic exp_t exp_reset();
    exp_t r;
    r = '0;
    r.chk_chg = 1'b1; r.chk_loc = 1'b1; r.chk_f = 1'b1;
    return r;
  endfunction

  function automatic exp_t exp_ctrl(input logic [2:0] pje, input logic fl);
    exp_t r;
    r = '0;
    r.c.pje = pje; r.c.fl = fl;
    return r;
  endfunction

  // Drive one window, record its expectation, advance to just after the edge.
  task automatic apply(input logic [31:0] w, input logic rst, input exp_t x);
    fetchoutput = w;
    reset = rst;
    sb.push_back(x);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    exp_t x;
    apply(32'hDEAD_BEEF, 1'b1, exp_reset());
    apply(32'h6005_0001, 1'b1, exp_reset());
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front(); vectors++;
      if (oc !== e.c || pcchange !== e.chg || pclocation !== e.loc || of !== e.f) begin
        miscompares++;
        $display("FAIL reset[%0d] got ctrl=%b chg=%h loc=%h f=%h want ctrl=%b chg=%h loc=%h f=%h",
                 i, oc, pcchange, pclocation, of, e.c, e.chg, e.loc, e.f);
      end
    end
    x = '0; x.c.valid = 1'b1; x.chk_f = 1'b1;
    x.f = {2'd0, 4'd1, 6'd1, 6'd2, 6'd3, 10'h013};
    apply(32'h0253_0001, 1'b0, x);
    e = sb.pop_front(); vectors++;
    if (oc !== e.c) begin miscompares++; $display("FAIL first_decode ctrl got %b want %b", oc, e.c); end
    if (of !== e.f) begin miscompares++; $display("FAIL first_decode fields got %h want %h", of, e.f); end
  endtask

  task automatic test_short();
    logic [31:0] w [5];
    exp_t x;
    w = '{32'h1F7F_0000, 32'h0000_1234, 32'h2ABC_FFFF, 32'h0001_0253, 32'h5555_AAAA};
    for (int i = 0; i < 5; i++) begin
      apply(w[i], 1'b0, model_run(w[i]));
      e = sb.pop_front(); vectors++;
      if (oc !== e.c) begin miscompares++; $display("FAIL short[%0d] ctrl got %b want %b", i, oc, e.c); end
      if (e.chk_f && of !== e.f) begin miscompares++; $display("FAIL short[%0d] fields got %h want %h", i, of, e.f); end
    end
    // hand-derived: 0x1F7F -> class 0, op 15, rd 5, ra 7, rb 7, imm 0x3F
    x = '0; x.c.valid = 1'b1; x.chk_f = 1'b1;
    x.f = {2'd0, 4'd15, 6'd5, 6'd7, 6'd7, 10'h03F};
    apply(32'h1F7F_0000, 1'b0, x);
    e = sb.pop_front(); vectors++;
    if (oc !== e.c || of !== e.f) begin
      miscompares++; $display("FAIL short_hand got ctrl=%b f=%h want ctrl=%b f=%h", oc, of, e.c, e.f);
    end
  endtask

  task automatic test_long();
    exp_t x [3];
    logic [31:0] w [3];
    w = '{32'h8253_0049, 32'h0049_0001, 32'hE000_0000};
    for (int i = 0; i < 3; i++) x[i] = '0;
`ifdef DECODE_LONG_INSN_EN
    x[0].c.valid = 1'b1; x[0].c.lng = 1'b1; x[0].chk_f = 1'b1;
    x[0].f = {2'd0, 4'd1, 6'd9, 6'd10, 6'd11, 10'h013};
`else
    x[0].c.ill = 1'b1;
    x[1].c.valid = 1'b1; x[1].chk_f = 1'b1;
    x[1].f = {2'd0, 4'd0, 6'd1, 6'd1, 6'd1, 10'h009};
`endif
    x[2].c.ill = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(w[i], 1'b0, x[i]);
      e = sb.pop_front(); vectors++;
      if (oc !== e.c) begin miscompares++; $display("FAIL long[%0d] ctrl got %b want %b", i, oc, e.c); end
      if (e.chk_f && of !== e.f) begin miscompares++; $display("FAIL long[%0d] fields got %h want %h", i, of, e.f); end
    end
  endtask

  task automatic test_branch();
    logic [31:0] w [4];
    exp_t x [5];
    w = '{32'h6005_0001, 32'h6414_0001, 32'h6321_0001, 32'h673F_0001};
    for (int b = 0; b < 4; b++) begin
      x[0] = model_run(w[b]);
      x[1] = x[0]; x[1].c.valid = 1'b0; x[1].chk_f = 1'b0;
      x[2] = exp_ctrl(3'd0, 1'b1);
      x[3] = exp_ctrl(3'd0, 1'b0);
      x[4] = model_run(32'h0253_0001);
      for (int i = 0; i < 5; i++) begin
        // stale words during redirect would decode if not discarded
        apply((i == 0) ? w[b] : 32'h0253_0001, 1'b0, x[i]);
        e = sb.pop_front(); vectors++;
        if (oc !== e.c) begin miscompares++; $display("FAIL branch%0d[%0d] ctrl got %b want %b", b, i, oc, e.c); end
        if (e.chk_chg && pcchange !== e.chg) begin miscompares++; $display("FAIL branch%0d[%0d] pcchange got %h want %h", b, i, pcchange, e.chg); end
        if (e.chk_loc && pclocation !== e.loc) begin miscompares++; $display("FAIL branch%0d[%0d] pclocation got %h want %h", b, i, pclocation, e.loc); end
        if (e.chk_f && of !== e.f) begin miscompares++; $display("FAIL branch%0d[%0d] fields got %h want %h", b, i, of, e.f); end
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] w [4];
    exp_t x [4];
    w = '{32'h6A00_0001, 32'h0253_0001, 32'h7E00_0000, 32'h0253_0001};
    for (int i = 0; i < 4; i++) x[i] = (i % 2 == 0) ? exp_ctrl(3'd0, 1'b0) : model_run(w[i]);
    x[0].c.ill = 1'b1; x[2].c.ill = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apply(w[i], 1'b0, x[i]);
      e = sb.pop_front(); vectors++;
      if (oc !== e.c) begin miscompares++; $display("FAIL illegal[%0d] ctrl got %b want %b", i, oc, e.c); end
      if (e.chk_f && of !== e.f) begin miscompares++; $display("FAIL illegal[%0d] fields got %h want %h", i, of, e.f); end
    end
  endtask

  task automatic test_reset_redirect();
    exp_t x [4];
    x[0] = model_run(32'h6005_0001);
    x[1] = x[0]; x[1].c.valid = 1'b0; x[1].chk_f = 1'b0;
    x[2] = exp_reset();
    x[3] = model_run(32'h0253_0001);
    for (int i = 0; i < 4; i++) begin
      apply((i == 0) ? 32'h6005_0001 : 32'h0253_0001, (i == 2), x[i]);
      e = sb.pop_front(); vectors++;
      if (oc !== e.c) begin miscompares++; $display("FAIL rst_redirect[%0d] ctrl got %b want %b", i, oc, e.c); end
      if (e.chk_chg && pcchange !== e.chg) begin miscompares++; $display("FAIL rst_redirect[%0d] pcchange got %h want %h", i, pcchange, e.chg); end
      if (e.chk_f && of !== e.f) begin miscompares++; $display("FAIL rst_redirect[%0d] fields got %h want %h", i, of, e.f); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] o;
    logic [31:0] w;
    for (int i = 0; i < 24; i++) begin
      o = 16'($urandom);
      o[15] = 1'b0;
      if (o[14:13] == 2'b11) o[14:13] = 2'b01;
      if (o <= 16'h0001) o = 16'h0253;
      w = {o, 16'($urandom)};
      apply(w, 1'b0, model_run(w));
      e = sb.pop_front(); vectors++;
      if (oc !== e.c) begin miscompares++; $display("FAIL b2b16[%0d] ctrl got %b want %b", i, oc, e.c); end
      if (of !== e.f) begin miscompares++; $display("FAIL b2b16[%0d] fields got %h want %h", i, of, e.f); end
    end
`ifdef DECODE_LONG_INSN_EN
    for (int i = 0; i < 8; i++) begin
      logic [15:0] sec;
      o = 16'($urandom);
      o[15] = 1'b1;
      if (o[14:13] == 2'b11) o[14:13] = 2'b10;
      sec = (i % 2 == 0) ? 16'h6005 : 16'($urandom);
      w = {o, sec};
      apply(w, 1'b0, model_run(w));
      apply({sec, 16'h0001}, 1'b0, exp_ctrl(3'd0, 1'b0));
      for (int k = 0; k < 2; k++) begin
        e = sb.pop_front(); vectors++;
        if (oc !== e.c) begin miscompares++; $display("FAIL b2b32[%0d.%0d] ctrl got %b want %b", i, k, oc, e.c); end
        if (e.chk_f && of !== e.f) begin miscompares++; $display("FAIL b2b32[%0d.%0d] fields got %h want %h", i, k, of, e.f); end
      end
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    fetchoutput = 32'h0;
    @(posedge clock);
    #1;
    test_reset();
    test_short();
    test_long();
    test_branch();
    test_illegal();
    test_reset_redirect();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/decode.md
# decode

Instruction decode stage, directly downstream of `fetch`. Each cycle it samples the 32-bit fetch window `{older word, newer word}`. It classifies the older word as a bubble, a 16-bit instruction or the prefix of a 32-bit instruction, and registers the decoded fields for execute. For flow-control instructions it drives the redirect controls back into `fetch` and then discards the stale window words.

## Interface
Parameters:
- `REDIRECT_HOLD`, default 2: number of cycles the jump controls are held toward fetch.

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fetchoutput`  in  32  fetch window; [31:16] is the older word (decoded), [15:0] is the newer word.
- `dec_valid`  out  1  decoded fields are valid this cycle.
- `dec_class`  out  2  instruction class, old[14:13].
- `dec_opcode`  out  4  old[12:9].
- `dec_rd` / `dec_ra` / `dec_rb`  out  6 each  register numbers.
- `dec_imm`  out  10  immediate.
- `dec_long`  out  1  decoded instruction was 32-bit.
- `dec_illegal`  out  1  one-cycle pulse for an undecodable word.
- `pcjumpenable`  out  3  redirect command to fetch: 0 run, 1 BRA, 2 JMP, 3 JAL, 4 BAL.
- `pcchange`  out  9  relative offset to fetch.
- `pclocation`  out  6  absolute target to fetch.
- `flush`  out  1  tells fetch to overwrite its older word with a bubble.

## Operation
- Bubble: an older word equal to 16'h0000 or 16'h0001. A bubble decodes to `dec_valid`=0.
- 16-bit format (old[15]=0):
  - rd = {3'b0, old[8:6]}, ra = {3'b0, old[5:3]}, rb = {3'b0, old[2:0]}.
  - imm = {4'b0, old[5:0]}.
- 32-bit format (old[15]=1, new = second half):
  - rd = {new[8:6], old[8:6]}, ra = {new[5:3], old[5:3]}, rb = {new[2:0], old[2:0]}.
  - imm = {new[12:9], old[5:0]}.
- Flow control applies to class 2'b11 in the 16-bit format only:
  - opcode 0 BRA: `pcjumpenable`=1, `pcchange`=old[8:0].
  - opcode 1 BAL: `pcjumpenable`=4, `pcchange`=old[8:0].
  - opcode 2 JMP: `pcjumpenable`=2, `pclocation`=old[5:0].
  - opcode 3 JAL: `pcjumpenable`=3, `pclocation`=old[5:0].
  - Class 11 with opcode ≥4, and any class 11 in the 32-bit format, are illegal.
- Flow-control instructions are still emitted on `dec_*` with `dec_valid`=1.
- Illegal word: `dec_illegal`=1 for one cycle, `dec_valid`=0, state stays RUN.
- FSM states: RUN, SKIP, REDIRECT, DRAIN.
  - RUN:
    - 32-bit instruction → SKIP.
    - Flow control → REDIRECT, counter loaded with `REDIRECT_HOLD`-1.
    - Anything else → stay in RUN.
  - SKIP: the older word is the second half of the previous instruction; ignore it, `dec_valid`=0 → RUN.
  - REDIRECT:
    - Hold `pcjumpenable`/`pcchange`/`pclocation` constant; `dec_valid`=0.
    - Decrement the counter. When the counter is 0, clear `pcjumpenable` to 0, assert `flush` for one cycle → DRAIN.
  - DRAIN: discard one window, `dec_valid`=0 → RUN.
- Only RUN decodes. SKIP, REDIRECT and DRAIN never raise `dec_illegal`.
- Reset in any state forces RUN. All outputs go to 0: `dec_valid`, `dec_*` fields, `dec_illegal`, `pcjumpenable`=0, `pcchange`=0, `pclocation`=0, `flush`=0.

## Timing
- All outputs are registered. A window sampled at edge N appears on `dec_*` after edge N.
- Latency: 1 cycle.
- `pcjumpenable` becomes non-zero in the same cycle as the branch's `dec_valid`. It stays non-zero for exactly `REDIRECT_HOLD` cycles, then returns to 0.
- `flush` rises in the cycle `pcjumpenable` returns to 0 and lasts 1 cycle.
- Back-to-back 32-bit instructions sustain 1 instruction per 2 cycles. 16-bit instructions sustain 1 per cycle.
- Branch throughput: branch decode, then `REDIRECT_HOLD` cycles, then 1 DRAIN cycle, then the first target decode.
- If reset is asserted at edge N, all outputs are at reset values after edge N, even in the middle of REDIRECT.

## Configuration
- `DECODE_LONG_INSN_EN` defined:
  - 32-bit format decoded as above; SKIP state present.
- `DECODE_LONG_INSN_EN` undefined:
  - Any non-bubble word with old[15]=1 is illegal: `dec_illegal` pulses, `dec_valid`=0, no SKIP.
  - `dec_long` is tied to 0.
  - rd/ra/rb[5:3] and imm[9:6] are always 0.

## Test plan
- Reset held 2 cycles, then window 0x0253_0001 → cycle after: `dec_valid`=1, class=0, opcode=1, rd=1, ra=2, rb=3, imm=0x013, `dec_long`=0.
- Window 0x8253_0049, next window 0x0049_0001 (LONG_INSN_EN) → `dec_long`=1, rd=9, ra=10, rb=11; the following cycle `dec_valid`=0 (SKIP).
- Window 0x6005_0001 → `dec_valid`=1, `pcjumpenable`=1 and `pcchange`=0x005 for 2 cycles, then `pcjumpenable`=0 with `flush`=1 for 1 cycle, then 1 DRAIN cycle with `dec_valid`=0.
- Window 0x6414_xxxx → `pcjumpenable`=2, `pclocation`=0x14 for 2 cycles.
- Window 0x6A00_0001 (class 11, opcode 5) → `dec_illegal`=1 for 1 cycle, `pcjumpenable`=0. Same test without the macro on 0x8253: `dec_illegal`=1.
- Reset asserted during the 2nd REDIRECT cycle → next cycle `pcjumpenable`=0, `flush`=0, `dec_valid`=0; the subsequent 0x0253 decodes normally.
